enemy_projectile_engine: RTL and testbench
==========================================

// Module: enemy_projectile_engine
// PURPOSE
//  Hit source for the player controller: owns NUM_PROJ falling enemy projectiles,
//  spawns them periodically, moves them on pulse_stepCycle and tests them
//  against the player box. Generates the one-cycle playerHit pulse that the
//  player controller consumes. Exports per-slot positions to the VGA renderer.
// PARAMETERS
//  NUM_PROJ        4       projectile slots
//  PROJ_W          10      projectile width, px
//  PROJ_H          10      projectile height, px
//  PROJ_STEP       8       px moved down per pulse_stepCycle
//  SPAWN_PERIOD    20      step pulses between spawn attempts (>=2)
//  TOP_Y           35      spawn Y (top of visible area)
//  BOTTOM_BOUNDARY 515     bottom of visible area
//  LEFT_BOUNDARY   144     left edge of visible area
//  RIGHT_BOUNDARY  784     right edge of visible area
//  LFSR_SEED       16'hACE1  LFSR reset value, nonzero
// PORTS
//  clk_master      in   1            system clock
//  rst             in   1            synchronous, active-high reset
//  pulse_stepCycle in   1            one-cycle game-step strobe
//  enable          in   1            game running; 0 freezes block, playerHit=0
//  playerX         in   10           player box left X
//  playerY         in   9            player box top Y
//  playerW         in   10           player box width
//  playerH         in   9            player box height
//  immune          in   1            player invulnerable
//  playerHit       out  1            one-cycle hit pulse, registered
//  projX           out  NUM_PROJ*10  slot i X at [10*i+9:10*i]
//  projY           out  NUM_PROJ*10  slot i Y at [10*i+9:10*i]
//  projValid       out  NUM_PROJ     slot i active
//  hitCount        out  8            hits delivered, saturates at 255
// BEHAVIOUR
//  Reset: projValid=0, projX/projY=0, playerHit=0, hitCount=0, spawn counter=0,
//   holdoff=0, LFSR=LFSR_SEED, lane=0. Mid-operation reset clears all state on
//   the next edge.
//  Step: enable&&pulse_stepCycle: each valid slot Y+=PROJ_STEP. If new
//   Y+PROJ_H >= BOTTOM_BOUNDARY, the slot goes invalid. Spawn counter increments.
//   At SPAWN_PERIOD-1 the counter returns to 0 and a spawn is attempted.
//  Spawn: lowest-index invalid slot gets Y=TOP_Y, X=spawnX, valid=1. It does
//   not move on its spawn step. All slots full: spawn is dropped, counter
//   still wraps.
//  Collision, evaluated every cycle while enable=1, valid slots only, 11-bit
//   math. Overlap = pX<plX+plW && pX+PROJ_W>plX && pY<plY+plH && pY+PROJ_H>plY.
//  Hit: the lowest-index overlapping slot is cleared at the next edge. Other
//   overlapping slots wait for later cycles. If immune=0 and holdoff=0:
//   playerHit=1 for exactly that cycle, hitCount++ (saturating), holdoff=2.
//  Immune or holdoff>0: the slot is still cleared, with no pulse and no count.
//  holdoff decrements each cycle. It covers the latency before the
//   controller's immune flag takes effect.
//  Collision in the same cycle as a step: the cleared slot is not moved and is
//   not eligible for that cycle's spawn. Free-slot search uses pre-edge
//   projValid.
//  enable=0: positions, counter and holdoff are frozen. No hits are flagged.
//   The LFSR keeps running.
// CONFIGURATION
//  PROJ_RANDOM_X_EN defined: 16-bit Galois LFSR (taps 16,14,13,11) advances
//   every cycle. c=lfsr[9:0]; spawnX = LEFT_BOUNDARY + (c>=630 ? c-512 : c).
//  Undefined: no LFSR logic. spawnX = LEFT_BOUNDARY+40+80*lane. The 3-bit lane
//   increments per successful spawn and wraps 7->0 (184,264,...,744).
// TESTING
//  rst, enable=1, no player overlap, 20 step pulses -> slot0 valid, Y=35;
//   no macro: X=184.
//  Slot0 at Y=35, 10 more steps -> Y=115; step where Y+8+10>=515 -> projValid[0]=0.
//  Player at (449,450,30,30), immune=0, force slot0 overlap -> playerHit high
//   1 cycle, slot0 cleared, hitCount=1.
//  Two slots overlap in the same cycle -> exactly one playerHit, slot0 cleared
//   first, second clear silent (holdoff), hitCount=1.
//  immune=1 during overlap -> slot cleared, playerHit=0, hitCount unchanged;
//   4 slots full at spawn -> no change.
//  rst asserted with 3 valid slots and holdoff=1 -> next edge all outputs at
//   reset values; hitCount=255 plus hit -> stays 255.

Source files
------------

// File: rtl/enemy_projectile_engine.sv
// enemy_projectile_engine: owns NUM_PROJ falling enemy projectiles, spawns them
// every SPAWN_PERIOD step pulses, moves them on pulse_stepCycle and tests them
// against the player box, producing a one-cycle registered playerHit pulse.
// Optional feature macro: PROJ_RANDOM_X_EN (LFSR-driven spawn X). Without it the
// spawn X walks through eight fixed lanes.
module enemy_projectile_engine #(
  parameter int unsigned NUM_PROJ        = 4,
  parameter int unsigned PROJ_W          = 10,
  parameter int unsigned PROJ_H          = 10,
  parameter int unsigned PROJ_STEP       = 8,
  parameter int unsigned SPAWN_PERIOD    = 20,
  parameter int unsigned TOP_Y           = 35,
  parameter int unsigned BOTTOM_BOUNDARY = 515,
  parameter int unsigned LEFT_BOUNDARY   = 144,
  parameter int unsigned RIGHT_BOUNDARY  = 784,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                   clk_master,
  input  logic                   rst,
  input  logic                   pulse_stepCycle,
  input  logic                   enable,
  input  logic [9:0]             playerX,
  input  logic [8:0]             playerY,
  input  logic [9:0]             playerW,
  input  logic [8:0]             playerH,
  input  logic                   immune,
  output logic                   playerHit,
  output logic [NUM_PROJ*10-1:0] projX,
  output logic [NUM_PROJ*10-1:0] projY,
  output logic [NUM_PROJ-1:0]    projValid,
  output logic [7:0]             hitCount
);

  localparam int unsigned CW    = 10;
  localparam int unsigned MW    = 11;
  localparam int unsigned CNT_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

  logic [NUM_PROJ-1:0][CW-1:0] x_q, x_d, y_q, y_d;
  logic [NUM_PROJ-1:0]         valid_q, valid_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [1:0]                  holdoff_q, holdoff_d;
  logic                        hit_q, hit_d;
  logic [7:0]                  hit_count_q, hit_count_d;
  logic [CW-1:0]               spawn_x;
  logic [NUM_PROJ-1:0]         overlap, hit_sel, free_sel;
  logic [MW-1:0]               pl_x_end, pl_y_end;
  logic                        do_step;

  assign do_step  = enable && pulse_stepCycle;
  assign pl_x_end = MW'(playerX) + MW'(playerW);
  assign pl_y_end = MW'(playerY) + MW'(playerH);

`ifdef PROJ_RANDOM_X_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic [9:0]  lfsr_c;
  logic [31:0] unused_cfg;

  assign unused_cfg = 32'(RIGHT_BOUNDARY);
  assign lfsr_c     = lfsr_q[9:0];
  assign spawn_x    = CW'(LEFT_BOUNDARY) + ((lfsr_c >= 10'd630) ? (lfsr_c - 10'd512) : lfsr_c);

  // Galois LFSR step (taps 16,14,13,11); free-runs regardless of enable
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  // LFSR register
  always_ff @(posedge clk_master) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end
`else
  logic [2:0]  lane_q, lane_d;
  logic [31:0] unused_cfg;

  assign unused_cfg = 32'(RIGHT_BOUNDARY) ^ {16'd0, LFSR_SEED};
  assign spawn_x    = CW'(LEFT_BOUNDARY + 40) + CW'(80) * CW'(lane_q);

  // Lane register, advanced only by a successful spawn
  always_ff @(posedge clk_master) begin
    if (rst) lane_q <= 3'd0;
    else     lane_q <= lane_d;
  end
`endif

  // Per-slot box overlap against the player, 11-bit to avoid wrap
  always_comb begin
    overlap = '0;
    for (int unsigned i = 0; i < NUM_PROJ; i++) begin
      overlap[i] = valid_q[i] &&
                   (MW'(x_q[i]) < pl_x_end) &&
                   (MW'(x_q[i]) + MW'(PROJ_W) > MW'(playerX)) &&
                   (MW'(y_q[i]) < pl_y_end) &&
                   (MW'(y_q[i]) + MW'(PROJ_H) > MW'(playerY));
    end
  end

  // Lowest-index overlapping slot and lowest-index free slot (pre-edge valid)
  always_comb begin
    logic hit_found;
    logic free_found;
    hit_sel    = '0;
    free_sel   = '0;
    hit_found  = 1'b0;
    free_found = 1'b0;
    for (int unsigned i = 0; i < NUM_PROJ; i++) begin
      if (enable && overlap[i] && !hit_found) begin
        hit_sel[i] = 1'b1;
        hit_found  = 1'b1;
      end
      if (!valid_q[i] && !free_found) begin
        free_sel[i] = 1'b1;
        free_found  = 1'b1;
      end
    end
  end

  // Next state: movement, spawn, hit clearing, pulse and holdoff
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    valid_d     = valid_q;
    cnt_d       = cnt_q;
    holdoff_d   = holdoff_q;
    hit_d       = 1'b0;
    hit_count_d = hit_count_q;
`ifndef PROJ_RANDOM_X_EN
    lane_d      = lane_q;
`endif
    if (enable) begin
      if (holdoff_q != 2'd0) holdoff_d = holdoff_q - 2'd1;
      if (do_step) begin
        for (int unsigned i = 0; i < NUM_PROJ; i++) begin
          if (valid_q[i] && !hit_sel[i]) begin
            y_d[i] = y_q[i] + CW'(PROJ_STEP);
            if (MW'(y_q[i]) + MW'(PROJ_STEP) + MW'(PROJ_H) >= MW'(BOTTOM_BOUNDARY))
              valid_d[i] = 1'b0;
          end
        end
        if (cnt_q == CNT_W'(SPAWN_PERIOD - 1)) begin
          cnt_d = '0;
          if (|free_sel) begin
            for (int unsigned i = 0; i < NUM_PROJ; i++) begin
              if (free_sel[i]) begin
                x_d[i]     = spawn_x;
                y_d[i]     = CW'(TOP_Y);
                valid_d[i] = 1'b1;
              end
            end
`ifndef PROJ_RANDOM_X_EN
            lane_d = lane_q + 3'd1;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      if (|hit_sel) begin
        valid_d = valid_d & ~hit_sel;
        if (!immune && holdoff_q == 2'd0) begin
          hit_d     = 1'b1;
          holdoff_d = 2'd2;
          if (hit_count_q != 8'hFF) hit_count_d = hit_count_q + 8'd1;
        end
      end
    end
  end

  // State registers
  always_ff @(posedge clk_master) begin
    if (rst) begin
      x_q         <= '0;
      y_q         <= '0;
      valid_q     <= '0;
      cnt_q       <= '0;
      holdoff_q   <= 2'd0;
      hit_q       <= 1'b0;
      hit_count_q <= 8'd0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
      holdoff_q   <= holdoff_d;
      hit_q       <= hit_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign playerHit = hit_q;
  assign projX     = x_q;
  assign projY     = y_q;
  assign projValid = valid_q;
  assign hitCount  = hit_count_q;

endmodule

// File: tb/tb_enemy_projectile_engine.sv
// Testbench for enemy_projectile_engine (default build, fixed spawn lanes).
module tb_enemy_projectile_engine;

  logic        clk_master = 1'b0;
  logic        rst = 1'b1;
  logic        pulse_stepCycle = 1'b0;
  logic        enable = 1'b0;
  logic [9:0]  playerX = 10'd0;
  logic [8:0]  playerY = 9'd0;
  logic [9:0]  playerW = 10'd10;
  logic [8:0]  playerH = 9'd10;
  logic        immune = 1'b0;
  logic        playerHit;
  logic [39:0] projX, projY;
  logic [3:0]  projValid;
  logic [7:0]  hitCount;
  logic        f_playerHit;
  logic [39:0] f_projX, f_projY;
  logic [3:0]  f_projValid;
  logic [7:0]  f_hitCount;

  int n_checks = 0;
  int n_fail = 0;
  int hit_pulses = 0;
  int exp_q[$];

  always #5 clk_master = ~clk_master;

  enemy_projectile_engine dut (
    .clk_master(clk_master), .rst(rst), .pulse_stepCycle(pulse_stepCycle),
    .enable(enable), .playerX(playerX), .playerY(playerY), .playerW(playerW),
    .playerH(playerH), .immune(immune), .playerHit(playerHit), .projX(projX),
    .projY(projY), .projValid(projValid), .hitCount(hitCount)
  );

  // Second instance with a short spawn period so all slots can fill up
  enemy_projectile_engine #(.SPAWN_PERIOD(2)) dut_fast (
    .clk_master(clk_master), .rst(rst), .pulse_stepCycle(pulse_stepCycle),
    .enable(enable), .playerX(10'd0), .playerY(9'd0), .playerW(10'd10),
    .playerH(9'd10), .immune(1'b0), .playerHit(f_playerHit), .projX(f_projX),
    .projY(f_projY), .projValid(f_projValid), .hitCount(f_hitCount)
  );

  always @(negedge clk_master) if (playerHit === 1'b1) hit_pulses++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [9:0] fld(input logic [39:0] v, input int i);
    return v[10*i +: 10];
  endfunction

  task automatic tick();
    @(posedge clk_master);
    #1;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      pulse_stepCycle = 1'b1;
      tick();
      pulse_stepCycle = 1'b0;
      tick();
    end
  endtask

  task automatic set_player(input int x, input int y, input int w, input int h);
    playerX = 10'(x);
    playerY = 9'(y);
    playerW = 10'(w);
    playerH = 9'(h);
  endtask

  task automatic park();
    set_player(0, 0, 10, 10);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    enable = 1'b0;
    park();
    do_reset();
    n_checks++; if (projValid !== 4'b0000) begin n_fail++; $display("FAIL reset_valid: got %b want 0000", projValid); end
    n_checks++; if (projX !== 40'd0) begin n_fail++; $display("FAIL reset_x: got %h want 0", projX); end
    n_checks++; if (projY !== 40'd0) begin n_fail++; $display("FAIL reset_y: got %h want 0", projY); end
    n_checks++; if (playerHit !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %b want 0", playerHit); end
    n_checks++; if (hitCount !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", hitCount); end
  endtask

  task automatic test_spawn();
    enable = 1'b1;
    step(19);
    n_checks++; if (projValid !== 4'b0000) begin n_fail++; $display("FAIL spawn_early: got %b want 0000", projValid); end
    step(1);
    n_checks++; if (projValid !== 4'b0001) begin n_fail++; $display("FAIL spawn_valid: got %b want 0001", projValid); end
    n_checks++; if (fld(projY, 0) !== 10'd35) begin n_fail++; $display("FAIL spawn_y: got %0d want 35", fld(projY, 0)); end
    n_checks++; if (fld(projX, 0) !== 10'd184) begin n_fail++; $display("FAIL spawn_x: got %0d want 184", fld(projX, 0)); end
  endtask

  task automatic test_move();
    step(10);
    n_checks++; if (fld(projY, 0) !== 10'd115) begin n_fail++; $display("FAIL move_y10: got %0d want 115", fld(projY, 0)); end
    step(48);
    n_checks++; if (fld(projY, 0) !== 10'd499 || projValid !== 4'b0111) begin
      n_fail++; $display("FAIL move_last: y %0d valid %b want 499 0111", fld(projY, 0), projValid); end
    step(1);
    n_checks++; if (projValid !== 4'b0110) begin n_fail++; $display("FAIL move_bottom: got %b want 0110", projValid); end
    n_checks++; if (fld(projY, 1) !== 10'd347 || fld(projY, 2) !== 10'd187) begin
      n_fail++; $display("FAIL move_others: y1 %0d y2 %0d want 347 187", fld(projY, 1), fld(projY, 2)); end
    step(1);
    n_checks++; if (projValid !== 4'b0111 || fld(projX, 0) !== 10'd424 || fld(projY, 0) !== 10'd35) begin
      n_fail++; $display("FAIL respawn: valid %b x %0d y %0d want 0111 424 35", projValid, fld(projX, 0), fld(projY, 0)); end
  endtask

  task automatic test_hit();
    int budget, exp, p0;
    p0 = hit_pulses;
    exp_q.push_back(1);
    set_player(420, 30, 30, 30);
    budget = 0;
    while (playerHit !== 1'b1 && budget < 5) begin tick(); budget++; end
    n_checks++;
    if (playerHit !== 1'b1) begin n_fail++; $display("FAIL hit_pulse: playerHit %b want 1 within 5 cycles", playerHit); end
    else begin
      exp = exp_q.pop_front();
      n_checks++; if (hitCount !== 8'(exp)) begin n_fail++; $display("FAIL hit_count: got %0d want %0d", hitCount, exp); end
      n_checks++; if (projValid !== 4'b0110) begin n_fail++; $display("FAIL hit_clear: got %b want 0110", projValid); end
    end
    tick();
    n_checks++; if (playerHit !== 1'b0) begin n_fail++; $display("FAIL hit_width: got %b want 0", playerHit); end
    park();
    repeat (4) tick();
    n_checks++; if (hit_pulses - p0 !== 1) begin n_fail++; $display("FAIL hit_once: got %0d pulses want 1", hit_pulses - p0); end
  endtask

  task automatic test_back_to_back();
    int budget, exp, p0;
    p0 = hit_pulses;
    exp_q.push_back(2);
    set_player(250, 150, 150, 250);
    budget = 0;
    while (playerHit !== 1'b1 && budget < 5) begin tick(); budget++; end
    n_checks++;
    if (playerHit !== 1'b1) begin n_fail++; $display("FAIL dbl_pulse: playerHit %b want 1 within 5 cycles", playerHit); end
    else begin
      exp = exp_q.pop_front();
      n_checks++; if (hitCount !== 8'(exp)) begin n_fail++; $display("FAIL dbl_count: got %0d want %0d", hitCount, exp); end
      n_checks++; if (projValid !== 4'b0100) begin n_fail++; $display("FAIL dbl_first: got %b want 0100", projValid); end
    end
    tick();
    n_checks++; if (projValid !== 4'b0000 || playerHit !== 1'b0 || hitCount !== 8'd2) begin
      n_fail++; $display("FAIL dbl_second: valid %b hit %b count %0d want 0000 0 2", projValid, playerHit, hitCount); end
    park();
    repeat (4) tick();
    n_checks++; if (hit_pulses - p0 !== 1) begin n_fail++; $display("FAIL dbl_once: got %0d pulses want 1", hit_pulses - p0); end
  endtask

  task automatic test_freeze_immune();
    int p0;
    step(20);
    n_checks++; if (projValid !== 4'b0001 || fld(projX, 0) !== 10'd504) begin
      n_fail++; $display("FAIL lane4: valid %b x %0d want 0001 504", projValid, fld(projX, 0)); end
    p0 = hit_pulses;
    enable = 1'b0;
    set_player(500, 30, 30, 30);
    step(5);
    n_checks++; if (projValid !== 4'b0001 || fld(projY, 0) !== 10'd35 || hitCount !== 8'd2 || hit_pulses != p0) begin
      n_fail++; $display("FAIL freeze: valid %b y %0d count %0d pulses %0d want 0001 35 2 0", projValid, fld(projY, 0), hitCount, hit_pulses - p0); end
    park();
    enable = 1'b1;
    immune = 1'b1;
    set_player(500, 30, 30, 30);
    tick();
    n_checks++; if (projValid !== 4'b0000 || playerHit !== 1'b0) begin
      n_fail++; $display("FAIL immune_clear: valid %b hit %b want 0000 0", projValid, playerHit); end
    tick();
    n_checks++; if (hitCount !== 8'd2 || hit_pulses != p0) begin
      n_fail++; $display("FAIL immune_count: count %0d pulses %0d want 2 0", hitCount, hit_pulses - p0); end
    immune = 1'b0;
    park();
  endtask

  task automatic test_full();
    do_reset();
    park();
    step(8);
    n_checks++; if (f_projValid !== 4'b1111 || fld(f_projX, 3) !== 10'd424) begin
      n_fail++; $display("FAIL full_fill: valid %b x3 %0d want 1111 424", f_projValid, fld(f_projX, 3)); end
    step(2);
    n_checks++; if (f_projValid !== 4'b1111 || fld(f_projY, 0) !== 10'd99) begin
      n_fail++; $display("FAIL full_drop: valid %b y0 %0d want 1111 99", f_projValid, fld(f_projY, 0)); end
    step(51);
    n_checks++; if (f_projValid !== 4'b1110) begin n_fail++; $display("FAIL full_fall: got %b want 1110", f_projValid); end
    step(1);
    n_checks++; if (f_projValid !== 4'b1111 || fld(f_projX, 0) !== 10'd504) begin
      n_fail++; $display("FAIL full_lane: valid %b x0 %0d want 1111 504", f_projValid, fld(f_projX, 0)); end
  endtask

  task automatic test_mid_reset();
    int exp;
    do_reset();
    park();
    step(60);
    n_checks++; if (projValid !== 4'b0111 || fld(projY, 0) !== 10'd355) begin
      n_fail++; $display("FAIL mr_setup: valid %b y0 %0d want 0111 355", projValid, fld(projY, 0)); end
    exp_q.push_back(1);
    set_player(340, 30, 20, 20);
    tick();
    n_checks++; if (playerHit !== 1'b1) begin n_fail++; $display("FAIL mr_hit: got %b want 1", playerHit); end
    else begin
      exp = exp_q.pop_front();
      n_checks++; if (hitCount !== 8'(exp)) begin n_fail++; $display("FAIL mr_count: got %0d want %0d", hitCount, exp); end
    end
    park();
    tick();
    rst = 1'b1;
    tick();
    n_checks++; if (projValid !== 4'b0000 || projX !== 40'd0 || projY !== 40'd0 || playerHit !== 1'b0 || hitCount !== 8'd0) begin
      n_fail++; $display("FAIL mr_state: valid %b x %h y %h hit %b count %0d want all zero", projValid, projX, projY, playerHit, hitCount); end
    rst = 1'b0;
    step(19);
    n_checks++; if (projValid !== 4'b0000) begin n_fail++; $display("FAIL mr_counter: got %b want 0000", projValid); end
    step(1);
    n_checks++; if (projValid !== 4'b0001 || fld(projX, 0) !== 10'd184) begin
      n_fail++; $display("FAIL mr_lane: valid %b x %0d want 0001 184", projValid, fld(projX, 0)); end
    exp_q.push_back(1);
    set_player(180, 30, 20, 20);
    tick();
    n_checks++; if (playerHit !== 1'b1) begin n_fail++; $display("FAIL mr_holdoff: got %b want 1", playerHit); end
    else begin
      exp = exp_q.pop_front();
      n_checks++; if (hitCount !== 8'(exp)) begin n_fail++; $display("FAIL mr_count2: got %0d want %0d", hitCount, exp); end
    end
    park();
    repeat (4) tick();
  endtask

  task automatic test_saturate();
    int budget, exp;
    for (int k = 2; k <= 257; k++) exp_q.push_back(k > 255 ? 255 : k);
    set_player(0, 0, 1023, 100);
    pulse_stepCycle = 1'b1;
    budget = 0;
    while (exp_q.size() > 0 && budget < 257 * 21 + 50) begin
      tick();
      budget++;
      if (playerHit === 1'b1) begin
        exp = exp_q.pop_front();
        n_checks++; if (hitCount !== 8'(exp)) begin n_fail++; $display("FAIL sat_count: got %0d want %0d", hitCount, exp); end
      end
    end
    pulse_stepCycle = 1'b0;
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sat_timeout: %0d hits outstanding want 0", exp_q.size()); end
    n_checks++; if (hitCount !== 8'd255) begin n_fail++; $display("FAIL sat_final: got %0d want 255", hitCount); end
    park();
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_move();
    test_hit();
    test_back_to_back();
    test_freeze_immune();
    test_full();
    test_mid_reset();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
